mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Arbitrates one single-port unified memory between the CPU's instruction-fetch port and its data (load/store) port.
- Sits between PC/instruction fetch, the data-access path, and the shared memory macro.
- Sequences each access through a fixed-latency wait-state FSM.
- Drives cpu_stall to the PC and register file so that no state updates while any access is outstanding.

Parameters:
- AW, 16, address width
- DW, 16, data width
- MEM_LAT, 2, cycles from mem_en issue to valid mem_rdata (legal range 1..15)

Ports:
- CLK  in  1  clock; all state changes on rising edge
- RESET  in  1  synchronous, active-low reset
- if_req  in  1  fetch request; held until if_valid
- if_addr  in  AW  fetch address; held with if_req
- if_gnt  out  1  1-cycle pulse; fetch access issued this cycle
- if_valid  out  1  1-cycle pulse; if_rdata valid
- if_rdata  out  DW  fetched instruction; holds last value
- d_req  in  1  data request; held until d_valid
- d_we  in  1  1 = store, 0 = load
- d_memc  in  1  access-size control; passed to memory unchanged
- d_addr  in  AW  data address
- d_wdata  in  DW  store data
- d_gnt  out  1  1-cycle pulse; data access issued this cycle
- d_valid  out  1  1-cycle pulse; load data valid or store complete
- d_rdata  out  DW  load data; holds last value
- mem_en  out  1  memory access strobe, 1 cycle per access
- mem_we  out  1  memory write enable, qualified by mem_en
- mem_memc  out  1  size control to memory
- mem_addr  out  AW  memory address
- mem_wdata  out  DW  memory write data
- mem_rdata  in  DW  memory read data
- cpu_stall  out  1  high while any request is pending without its valid

Behaviour:
- States:
  - IDLE: no access in flight.
  - BUSY: access issued, counting wait states.
  - RESP: valid pulse out, requests ignored.
- All registered outputs are registered except cpu_stall, which is combinational: (if_req & ~if_valid) | (d_req & ~d_valid).
- Reset (RESET=0 at a rising edge):
  - State goes to IDLE, counter 0, last_owner = FETCH.
  - All outputs go to 0, including if_rdata, d_rdata, mem_addr and mem_wdata.
  - Any in-flight access is abandoned; no valid is produced for it.
  - The requester must re-request after reset.
- IDLE, rising edge with any request high:
  - Select a winner:
    - Only one requester high: it wins.
    - Both high: the requester not equal to last_owner wins, so back-to-back contention alternates.
  - In the next cycle (issue cycle T), registered outputs are:
    - mem_en=1, the winner's gnt=1.
    - mem_addr/mem_we/mem_memc/mem_wdata from the winner. Fetch forces mem_we=0, mem_memc=0, mem_wdata=0.
  - Update last_owner to the winner and load counter=0. State goes to BUSY.
- BUSY:
  - mem_en and gnt are low after cycle T.
  - mem_addr, mem_we and mem_wdata stay stable through BUSY.
  - Counter increments each edge.
  - At the edge where counter == MEM_LAT-1, capture mem_rdata into the owner's rdata register (stores leave rdata unchanged) and go to RESP.
- RESP:
  - The owner's valid=1 for exactly one cycle, at cycle T+MEM_LAT.
  - Requests sampled at the end of RESP are ignored; the requester drops req during RESP.
  - Next state is IDLE.
- Latency:
  - Request sampled at edge E, then mem_en at E+1, then valid at E+1+MEM_LAT.
  - Minimum access period is MEM_LAT+2 cycles.
- Simultaneous events:
  - The losing request stays pending with cpu_stall high and is served at the next IDLE.
  - No request is ever lost or duplicated.
- Counter width is 4 bits; no wrap, since MEM_LAT ≤ 15.
- Addresses pass through unchanged; no range checking.

Test Plan:
- Reset: hold RESET=0 for 3 cycles with if_req=1 -> all outputs 0, no mem_en. After release: mem_en in the first cycle after the first sampling edge.
- Single fetch, MEM_LAT=2: if_addr=0x0004, mem_rdata=0x1234 in the cycle after issue -> mem_en/if_gnt at T, if_valid at T+2 with if_rdata=0x1234, cpu_stall low from T+2 on.
- Store then load, same port, with d_we=1, d_addr=0x0010, d_wdata=0xBEEF, d_memc=1:
  - First access -> mem_we=1, mem_addr=0x0010, mem_wdata=0xBEEF, mem_memc=1 at T; d_valid at T+2; d_rdata unchanged.
  - Following load from 0x0010 -> d_rdata=0xBEEF.
- Contention: if_req and d_req rise together after reset -> fetch served first? No: last_owner=FETCH at reset, so data is served first, fetch second. Two mem_en pulses spaced exactly MEM_LAT+2=4 cycles apart, cpu_stall continuously high until the second valid.
- Reset mid-access: RESET=0 during BUSY -> no d_valid ever, outputs 0. The re-request after release completes normally.
- MEM_LAT=1 build: back-to-back fetches -> mem_en every 3 cycles, each if_valid 1 cycle after its mem_en, data captured correctly.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port memory between the instruction-fetch
// port and the data (load/store) port. Each access runs through a fixed-latency
// wait-state FSM: one issue cycle (mem_en + gnt), MEM_LAT-1 further wait
// cycles, then one RESP cycle carrying the owner's valid pulse.
//
// Handshake: a requester raises req with its address/data fields and holds
// them until its valid pulse. gnt pulses in the cycle the access is issued to
// memory; valid pulses once when load data is ready or a store has completed.
// The requester drops req in its valid cycle; a req seen during RESP is ignored.
module mem_port_arbiter #(
    parameter int AW      = 16,
    parameter int DW      = 16,
    parameter int MEM_LAT = 2
) (
    input  logic          CLK,
    input  logic          RESET,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic          if_gnt,
    output logic          if_valid,
    output logic [DW-1:0] if_rdata,
    input  logic          d_req,
    input  logic          d_we,
    input  logic          d_memc,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic          d_gnt,
    output logic          d_valid,
    output logic [DW-1:0] d_rdata,
    output logic          mem_en,
    output logic          mem_we,
    output logic          mem_memc,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          cpu_stall,
    output logic [1:0]    dbg_state
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    typedef enum logic {
        OWN_FETCH = 1'b0,
        OWN_DATA  = 1'b1
    } owner_t;

    // Counter value at which mem_rdata is valid and gets captured.
    localparam logic [3:0] LAST_CNT = 4'(MEM_LAT - 1);

    state_t          r_state;
    state_t          w_next_state;
    owner_t          r_last_owner;
    owner_t          w_win;
    logic            w_issue;
    logic            w_done;
    logic [3:0]      r_cnt;
    logic            r_mem_en;
    logic            r_mem_we;
    logic            r_mem_memc;
    logic [AW-1:0]   r_mem_addr;
    logic [DW-1:0]   r_mem_wdata;
    logic            r_if_gnt;
    logic            r_d_gnt;
    logic            r_if_valid;
    logic            r_d_valid;
    logic [DW-1:0]   r_if_rdata;
    logic [DW-1:0]   r_d_rdata;

    // State register.
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic, winner selection and issue/completion strobes.
    always_comb begin
        w_next_state = r_state;
        w_issue      = 1'b0;
        w_done       = 1'b0;
        w_win        = OWN_FETCH;
        case (r_state)
            ST_IDLE: begin
                if (if_req || d_req) begin
                    w_issue      = 1'b1;
                    w_next_state = ST_BUSY;
                    // Under contention the port that did not own the last access wins.
                    if (d_req && (!if_req || r_last_owner == OWN_FETCH)) begin
                        w_win = OWN_DATA;
                    end
                end
            end
            ST_BUSY: begin
                if (r_cnt == LAST_CNT) begin
                    w_done       = 1'b1;
                    w_next_state = ST_RESP;
                end
            end
            ST_RESP: begin
                w_next_state = ST_IDLE;
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // Registered memory bus, grant/valid pulses, wait counter and read-data capture.
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            r_last_owner <= OWN_FETCH;
            r_cnt        <= 4'd0;
            r_mem_en     <= 1'b0;
            r_mem_we     <= 1'b0;
            r_mem_memc   <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_wdata  <= '0;
            r_if_gnt     <= 1'b0;
            r_d_gnt      <= 1'b0;
            r_if_valid   <= 1'b0;
            r_d_valid    <= 1'b0;
            r_if_rdata   <= '0;
            r_d_rdata    <= '0;
        end else begin
            r_mem_en   <= w_issue;
            r_if_gnt   <= w_issue && (w_win == OWN_FETCH);
            r_d_gnt    <= w_issue && (w_win == OWN_DATA);
            r_if_valid <= w_done && (r_last_owner == OWN_FETCH);
            r_d_valid  <= w_done && (r_last_owner == OWN_DATA);
            if (w_issue) begin
                r_last_owner <= w_win;
                r_cnt        <= 4'd0;
                if (w_win == OWN_DATA) begin
                    r_mem_addr  <= d_addr;
                    r_mem_we    <= d_we;
                    r_mem_memc  <= d_memc;
                    r_mem_wdata <= d_wdata;
                end else begin
                    r_mem_addr  <= if_addr;
                    r_mem_we    <= 1'b0;
                    r_mem_memc  <= 1'b0;
                    r_mem_wdata <= '0;
                end
            end else if (r_state == ST_BUSY && !w_done) begin
                r_cnt <= r_cnt + 4'd1;
            end
            if (w_done) begin
                if (r_last_owner == OWN_FETCH) begin
                    r_if_rdata <= mem_rdata;
                end else if (!r_mem_we) begin
                    r_d_rdata <= mem_rdata;
                end
            end
        end
    end

    assign if_gnt    = r_if_gnt;
    assign if_valid  = r_if_valid;
    assign if_rdata  = r_if_rdata;
    assign d_gnt     = r_d_gnt;
    assign d_valid   = r_d_valid;
    assign d_rdata   = r_d_rdata;
    assign mem_en    = r_mem_en;
    assign mem_we    = r_mem_we;
    assign mem_memc  = r_mem_memc;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign dbg_state = r_state;

    // Stall while either port has a request that has not yet seen its valid.
    assign cpu_stall = (if_req & ~r_if_valid) | (d_req & ~r_d_valid);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: a MEM_LAT=2 instance (directed + randomized
// traffic against a request-level reference model) and a MEM_LAT=1 instance
// (back-to-back fetch timing).
module tb_mem_port_arbiter;

    localparam int A_LAT = 2;
    localparam int B_LAT = 1;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;
    int   cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- DUT A (MEM_LAT=2) ----------------
    logic        a_if_req, a_if_gnt, a_if_valid;
    logic [15:0] a_if_addr, a_if_rdata;
    logic        a_d_req, a_d_we, a_d_memc, a_d_gnt, a_d_valid;
    logic [15:0] a_d_addr, a_d_wdata, a_d_rdata;
    logic        a_mem_en, a_mem_we, a_mem_memc, a_stall;
    logic [15:0] a_mem_addr, a_mem_wdata, a_mem_rdata;
    logic [1:0]  a_dbg;

    mem_port_arbiter #(.AW(16), .DW(16), .MEM_LAT(A_LAT)) u_a (
        .CLK(clk), .RESET(rst_n),
        .if_req(a_if_req), .if_addr(a_if_addr), .if_gnt(a_if_gnt),
        .if_valid(a_if_valid), .if_rdata(a_if_rdata),
        .d_req(a_d_req), .d_we(a_d_we), .d_memc(a_d_memc), .d_addr(a_d_addr),
        .d_wdata(a_d_wdata), .d_gnt(a_d_gnt), .d_valid(a_d_valid), .d_rdata(a_d_rdata),
        .mem_en(a_mem_en), .mem_we(a_mem_we), .mem_memc(a_mem_memc),
        .mem_addr(a_mem_addr), .mem_wdata(a_mem_wdata), .mem_rdata(a_mem_rdata),
        .cpu_stall(a_stall), .dbg_state(a_dbg)
    );

    // ---------------- DUT B (MEM_LAT=1) ----------------
    logic        b_if_req, b_if_gnt, b_if_valid;
    logic [15:0] b_if_addr, b_if_rdata;
    logic        b_d_req, b_d_we, b_d_memc, b_d_gnt, b_d_valid;
    logic [15:0] b_d_addr, b_d_wdata, b_d_rdata;
    logic        b_mem_en, b_mem_we, b_mem_memc, b_stall;
    logic [15:0] b_mem_addr, b_mem_wdata, b_mem_rdata;
    logic [1:0]  b_dbg;

    mem_port_arbiter #(.AW(16), .DW(16), .MEM_LAT(B_LAT)) u_b (
        .CLK(clk), .RESET(rst_n),
        .if_req(b_if_req), .if_addr(b_if_addr), .if_gnt(b_if_gnt),
        .if_valid(b_if_valid), .if_rdata(b_if_rdata),
        .d_req(b_d_req), .d_we(b_d_we), .d_memc(b_d_memc), .d_addr(b_d_addr),
        .d_wdata(b_d_wdata), .d_gnt(b_d_gnt), .d_valid(b_d_valid), .d_rdata(b_d_rdata),
        .mem_en(b_mem_en), .mem_we(b_mem_we), .mem_memc(b_mem_memc),
        .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata), .mem_rdata(b_mem_rdata),
        .cpu_stall(b_stall), .dbg_state(b_dbg)
    );

    // Contents of never-written locations; init_val(16'h0004) == 16'h1234.
    function automatic logic [15:0] init_val(input logic [15:0] a);
        return (a * 16'h0101) ^ 16'h1630;
    endfunction

    // ---------------- memory models ----------------
    // Read data is only driven in the cycle the arbiter must sample it
    // (MEM_LAT-1 cycles after the mem_en cycle); 16'hDEAD otherwise.
    logic [15:0] mem_a [0:65535];
    bit          wr_a  [0:65535];
    int          a_age = 0;
    always @(posedge clk) begin
        if (a_mem_en) begin
            a_age <= 1;
            if (a_mem_we) begin
                mem_a[a_mem_addr] <= a_mem_wdata;
                wr_a[a_mem_addr]  <= 1'b1;
            end
        end else if (a_age != 0 && a_age < 100) begin
            a_age <= a_age + 1;
        end
    end
    assign a_mem_rdata = (!a_mem_en && a_age == A_LAT - 1) ?
                         (wr_a[a_mem_addr] ? mem_a[a_mem_addr] : init_val(a_mem_addr)) : 16'hDEAD;
    // MEM_LAT=1: data must be present in the issue cycle itself.
    assign b_mem_rdata = b_mem_en ? init_val(b_mem_addr) : 16'hDEAD;

    // ---------------- scoreboard ----------------
    int checks = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Wait (bounded) for a grant on port A: data=1 -> d_gnt, else if_gnt.
    task automatic wait_gnt_a(input bit data);
        int n;
        n = 0;
        do begin
            tick();
            n++;
        end while (!(data ? a_d_gnt : a_if_gnt) && n < 20);
        chk(data ? "a_d_gnt_wait" : "a_if_gnt_wait", data ? a_d_gnt : a_if_gnt, 1'b1);
    endtask

    // Request-level reference model state for randomized traffic.
    logic [15:0] shadow [0:65535];
    bit          sh_v   [0:65535];
    bit          if_pend, if_iss, if_was, d_pend, d_iss, d_was, exp_stall;
    int          if_t, if_start, d_t, d_start, prev_t, n;
    logic [15:0] if_addr_m, if_exp, d_addr_m, d_wdata_m, d_exp, d_last, b_addr;
    logic        d_we_m, d_memc_m;

    // Global watchdog.
    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        a_if_req = 0; a_if_addr = 0; a_d_req = 0; a_d_we = 0; a_d_memc = 0;
        a_d_addr = 0; a_d_wdata = 0;
        b_if_req = 0; b_if_addr = 0; b_d_req = 0; b_d_we = 0; b_d_memc = 0;
        b_d_addr = 0; b_d_wdata = 0;

        // ---- reset held 3 cycles with if_req high ----
        a_if_req = 1'b1; a_if_addr = 16'h0004;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rst_ctrl", {a_mem_en, a_if_gnt, a_if_valid, a_d_gnt, a_d_valid, a_mem_we, a_mem_memc}, 0);
            chk("rst_rdata", {a_if_rdata, a_d_rdata}, 0);
            chk("rst_bus", {a_mem_addr, a_mem_wdata}, 0);
        end
        rst_n = 1'b1;

        // ---- single fetch: mem_en right after first sampling edge ----
        tick();
        chk("fetch_issue", {a_mem_en, a_if_gnt, a_d_gnt}, 3'b110);
        chk("fetch_bus", {a_mem_addr, a_mem_we, a_mem_memc, a_mem_wdata}, {16'h0004, 2'b00, 16'h0000});
        tick();
        chk("fetch_wait", {a_mem_en, a_if_gnt, a_if_valid, a_stall}, 4'b0001);
        tick();
        chk("fetch_valid", a_if_valid, 1'b1);
        chk("fetch_rdata", a_if_rdata, 16'h1234);
        a_if_req = 1'b0;
        #1;
        chk("fetch_stall_low", a_stall, 1'b0);
        tick();
        chk("fetch_valid_pulse", {a_if_valid, a_stall}, 2'b00);
        chk("fetch_rdata_hold", a_if_rdata, 16'h1234);

        // ---- store then load on the data port ----
        a_d_req = 1'b1; a_d_we = 1'b1; a_d_memc = 1'b1; a_d_addr = 16'h0010; a_d_wdata = 16'hBEEF;
        wait_gnt_a(1'b1);
        chk("store_bus", {a_mem_en, a_mem_we, a_mem_memc, a_mem_addr, a_mem_wdata}, {3'b111, 16'h0010, 16'hBEEF});
        tick();
        chk("store_bus_stable", {a_mem_en, a_mem_we, a_mem_addr, a_mem_wdata}, {2'b01, 16'h0010, 16'hBEEF});
        tick();
        chk("store_valid", a_d_valid, 1'b1);
        chk("store_rdata_unchanged", a_d_rdata, 16'h0000);
        a_d_req = 1'b0;
        tick();
        a_d_req = 1'b1; a_d_we = 1'b0; a_d_memc = 1'b0; a_d_wdata = 16'h0000;
        wait_gnt_a(1'b1);
        chk("load_bus", {a_mem_we, a_mem_addr}, {1'b0, 16'h0010});
        tick();
        tick();
        chk("load_valid", a_d_valid, 1'b1);
        chk("load_rdata", a_d_rdata, 16'hBEEF);
        a_d_req = 1'b0;
        tick();

        // ---- contention after reset: data first, fetch 4 cycles later ----
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        a_if_req = 1'b1; a_if_addr = 16'h0020;
        a_d_req = 1'b1; a_d_we = 1'b0; a_d_addr = 16'h8000; a_d_wdata = 16'h0000;
        tick();
        chk("cont_first_data", {a_mem_en, a_if_gnt, a_d_gnt}, 3'b101);
        chk("cont_stall_0", a_stall, 1'b1);
        for (int i = 1; i <= 3; i++) begin
            tick();
            chk("cont_stall", a_stall, 1'b1);
            chk("cont_no_issue", a_mem_en, 1'b0);
            if (i == A_LAT) begin
                chk("cont_d_valid", a_d_valid, 1'b1);
                chk("cont_d_rdata", a_d_rdata, init_val(16'h8000));
                a_d_req = 1'b0;
                #1;
                chk("cont_stall_fetch_pending", a_stall, 1'b1);
            end
        end
        tick();
        chk("cont_second_fetch", {a_mem_en, a_if_gnt, a_d_gnt}, 3'b110);
        chk("cont_fetch_addr", a_mem_addr, 16'h0020);
        tick();
        chk("cont_stall_late", a_stall, 1'b1);
        tick();
        chk("cont_if_valid", {a_if_valid, a_if_rdata}, {1'b1, init_val(16'h0020)});
        a_if_req = 1'b0;
        #1;
        chk("cont_stall_end", a_stall, 1'b0);
        tick();

        // ---- reset during BUSY abandons the access ----
        a_d_req = 1'b1; a_d_we = 1'b0; a_d_addr = 16'h0010;
        wait_gnt_a(1'b1);
        tick();
        rst_n = 1'b0;
        tick();
        chk("midrst_ctrl", {a_mem_en, a_if_gnt, a_if_valid, a_d_gnt, a_d_valid, a_mem_we, a_mem_memc}, 0);
        chk("midrst_data", {a_if_rdata, a_d_rdata, a_mem_addr, a_mem_wdata}, 0);
        a_d_req = 1'b0;
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("midrst_no_valid", {a_d_valid, a_mem_en}, 2'b00);
        end
        a_d_req = 1'b1;
        wait_gnt_a(1'b1);
        tick();
        tick();
        chk("midrst_rereq", {a_d_valid, a_d_rdata}, {1'b1, 16'hBEEF});
        a_d_req = 1'b0;
        tick();

        // ---- randomized two-port traffic on A ----
        d_last = 16'hBEEF;
        if_pend = 0; if_iss = 0; d_pend = 0; d_iss = 0;
        for (int it = 0; it < 420; it++) begin
            tick();
            if_was = if_pend;
            d_was = d_pend;
            exp_stall = (if_pend && !a_if_valid) || (d_pend && !a_d_valid);
            chk("rnd_stall", a_stall, exp_stall);
            if (a_mem_en || a_if_gnt || a_d_gnt)
                chk("rnd_en_vs_gnt", {a_mem_en, a_if_gnt ^ a_d_gnt}, 2'b11);
            if (a_if_gnt) begin
                chk("rnd_if_gnt_ok", {if_pend, if_iss}, 2'b10);
                chk("rnd_if_bus", {a_mem_addr, a_mem_we, a_mem_memc, a_mem_wdata}, {if_addr_m, 2'b00, 16'h0000});
                if_iss = 1; if_t = cyc;
            end
            if (a_d_gnt) begin
                chk("rnd_d_gnt_ok", {d_pend, d_iss}, 2'b10);
                chk("rnd_d_bus", {a_mem_addr, a_mem_we, a_mem_memc, a_mem_wdata}, {d_addr_m, d_we_m, d_memc_m, d_wdata_m});
                d_iss = 1; d_t = cyc;
            end
            if (a_if_valid) begin
                chk("rnd_if_valid_ok", {if_pend, if_iss}, 2'b11);
                chk("rnd_if_lat", cyc - if_t, A_LAT);
                chk("rnd_if_data", a_if_rdata, if_exp);
                if_pend = 0; if_iss = 0; a_if_req = 1'b0;
            end
            if (a_d_valid) begin
                chk("rnd_d_valid_ok", {d_pend, d_iss}, 2'b11);
                chk("rnd_d_lat", cyc - d_t, A_LAT);
                if (!d_we_m) d_last = d_exp;
                chk("rnd_d_data", a_d_rdata, d_last);
                d_pend = 0; d_iss = 0; a_d_req = 1'b0;
            end
            if (if_pend && cyc - if_start > 14) begin
                chk("rnd_if_timeout", 1'b0, 1'b1);
                if_pend = 0; if_iss = 0; a_if_req = 1'b0;
            end
            if (d_pend && cyc - d_start > 14) begin
                chk("rnd_d_timeout", 1'b0, 1'b1);
                d_pend = 0; d_iss = 0; a_d_req = 1'b0;
            end
            if (it < 400 && !if_was && !if_pend && $urandom_range(0, 2) == 0) begin
                if_addr_m = 16'h0200 + 16'($urandom_range(0, 127) * 2);
                if_exp = init_val(if_addr_m);
                a_if_req = 1'b1; a_if_addr = if_addr_m;
                if_pend = 1; if_start = cyc;
            end
            if (it < 400 && !d_was && !d_pend && $urandom_range(0, 2) == 0) begin
                d_addr_m = 16'h8000 + 16'($urandom_range(0, 7) * 2);
                d_we_m = 1'($urandom_range(0, 1));
                d_memc_m = 1'($urandom_range(0, 1));
                d_wdata_m = 16'($urandom);
                if (d_we_m) begin
                    shadow[d_addr_m] = d_wdata_m;
                    sh_v[d_addr_m] = 1'b1;
                end else begin
                    d_exp = sh_v[d_addr_m] ? shadow[d_addr_m] : init_val(d_addr_m);
                end
                a_d_req = 1'b1; a_d_we = d_we_m; a_d_memc = d_memc_m;
                a_d_addr = d_addr_m; a_d_wdata = d_wdata_m;
                d_pend = 1; d_start = cyc;
            end
        end
        chk("rnd_drained", {if_pend, d_pend}, 2'b00);

        // ---- MEM_LAT=1: back-to-back fetches every 3 cycles ----
        b_addr = 16'h0100;
        b_if_req = 1'b1; b_if_addr = b_addr;
        prev_t = 0;
        for (int k = 0; k < 4; k++) begin
            n = 0;
            do begin
                tick();
                n++;
            end while (!b_mem_en && n < 10);
            chk("b_issue", {b_mem_en, b_if_gnt}, 2'b11);
            chk("b_addr", b_mem_addr, b_addr);
            if (k > 0) chk("b_period", cyc - prev_t, B_LAT + 2);
            prev_t = cyc;
            tick();
            chk("b_valid", {b_if_valid, b_mem_en}, 2'b10);
            chk("b_rdata", b_if_rdata, init_val(b_addr));
            b_addr = b_addr + 16'h0002;
            b_if_addr = b_addr;
        end
        b_if_req = 1'b0;
        tick();
        chk("b_idle", {b_if_valid, b_stall}, 2'b00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
